// File: rtl/pe_feeder.sv
// pe_feeder: sequences one pe_array output word. Reads K A-words and K
// B-elements from the global buffers, skews A lane k by k cycles to line up
// with the array's internal PE chain, pulses clr at the start and we once the
// last lane's partial sum has settled.
module pe_feeder #(
  parameter int LANES      = 10,
  parameter int DATA_WIDTH = 12,
  parameter int WORD_WIDTH = 128,
  parameter int ADDR_WIDTH = 10,
  parameter int KLEN_WIDTH = 16,
  parameter int WE_DELAY   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [KLEN_WIDTH-1:0] k_len_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [WORD_WIDTH-1:0] a_rd_data_i,
  input  logic [DATA_WIDTH-1:0] b_rd_data_i,
  output logic                  clr_o,
  output logic                  we_o,
  output logic [WORD_WIDTH-1:0] srca_word_o,
  output logic [DATA_WIDTH-1:0] srcb_o
);

  localparam int USED_BITS    = LANES * DATA_WIDTH;
  // Cycles between the last read and we: the deepest lane still needs
  // LANES-1 cycles to arrive, plus the PE psum register latency.
  localparam int DRAIN_CYCLES = LANES - 1 + WE_DELAY;
  localparam int DCNT_W       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, WRITE, DONE} state_t;

  state_t                state;
  logic [KLEN_WIDTH-1:0] k_len;
  logic [KLEN_WIDTH-1:0] rd_cnt;
  logic [DCNT_W-1:0]     drain_cnt;
  logic                  rvalid;

  logic [DATA_WIDTH-1:0] lane_in  [LANES];
  logic [DATA_WIDTH-1:0] lane_out [LANES];

  // Job sequencer; every control output is registered and set on the
  // transition into the state in which it must be visible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      k_len     <= '0;
      rd_cnt    <= '0;
      drain_cnt <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      rd_en_o   <= 1'b0;
      rd_addr_o <= '0;
      clr_o     <= 1'b0;
      we_o      <= 1'b0;
    end else begin
      clr_o  <= 1'b0;
      we_o   <= 1'b0;
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state     <= FEED;
            busy_o    <= 1'b1;
            clr_o     <= 1'b1;
            k_len     <= k_len_i;
            rd_cnt    <= KLEN_WIDTH'(1);
            rd_addr_o <= base_addr_i;
            rd_en_o   <= (k_len_i != '0);
          end
        end
        FEED: begin
          if (k_len == '0) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else if (rd_cnt == k_len) begin
            rd_en_o   <= 1'b0;
            drain_cnt <= '0;
            if (DRAIN_CYCLES == 0) begin
              state <= WRITE;
              we_o  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            rd_cnt    <= rd_cnt + KLEN_WIDTH'(1);
            rd_addr_o <= rd_addr_o + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == DCNT_W'(DRAIN_CYCLES - 1)) begin
            state <= WRITE;
            we_o  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DCNT_W'(1);
          end
        end
        WRITE: begin
          state  <= DONE;
          done_o <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer data is valid exactly one cycle after each read strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rvalid <= 1'b0;
    else         rvalid <= rd_en_o;
  end

  // Split the returned A word into lanes, forcing zero outside read-valid.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_in[k] = rvalid ? a_rd_data_i[k*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end

  assign lane_out[0] = lane_in[0];

  for (genvar k = 1; k < LANES; k++) begin : g_skew
    logic [DATA_WIDTH-1:0] sr [k];

    // Lane k passes through a k-deep shift register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int j = 0; j < k; j++) sr[j] <= '0;
      end else begin
        sr[0] <= lane_in[k];
        for (int j = 1; j < k; j++) sr[j] <= sr[j-1];
      end
    end

    assign lane_out[k] = sr[k-1];
  end

  // Reassemble the skewed lanes; bits above the used lanes stay zero.
  always_comb begin
    srca_word_o = '0;
    for (int k = 0; k < LANES; k++) begin
      srca_word_o[k*DATA_WIDTH +: DATA_WIDTH] = lane_out[k];
    end
  end

  assign srcb_o = rvalid ? b_rd_data_i : '0;

  if (WORD_WIDTH > USED_BITS) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^a_rd_data_i[WORD_WIDTH-1:USED_BITS];
  end

endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: scoreboard bench for pe_feeder. Each job pushes its expected
// per-cycle events (clr, reads, lane data, we, done) into a queue; a monitor
// pops and compares whenever the DUT shows an active control or nonzero data.
module tb_pe_feeder;

  localparam int LANES    = 10;
  localparam int DW       = 12;
  localparam int WW       = 128;
  localparam int AW       = 10;
  localparam int KW       = 16;
  localparam int WE_DELAY = 1;

  localparam int EV_CLR  = 0;
  localparam int EV_RD   = 1;
  localparam int EV_B    = 2;
  localparam int EV_L0   = 3;
  localparam int EV_L9   = 4;
  localparam int EV_WE   = 5;
  localparam int EV_DONE = 6;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [KW-1:0] k_len_i;
  logic [AW-1:0] base_addr_i;
  logic          busy_o;
  logic          done_o;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [WW-1:0] a_rd_data_i = '1;
  logic [DW-1:0] b_rd_data_i = '1;
  logic          clr_o;
  logic          we_o;
  logic [WW-1:0] srca_word_o;
  logic [DW-1:0] srcb_o;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t expq[$];

  pe_feeder #(
    .LANES(LANES), .DATA_WIDTH(DW), .WORD_WIDTH(WW),
    .ADDR_WIDTH(AW), .KLEN_WIDTH(KW), .WE_DELAY(WE_DELAY)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .k_len_i(k_len_i),
    .base_addr_i(base_addr_i), .busy_o(busy_o), .done_o(done_o),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .a_rd_data_i(a_rd_data_i),
    .b_rd_data_i(b_rd_data_i), .clr_o(clr_o), .we_o(we_o),
    .srca_word_o(srca_word_o), .srcb_o(srcb_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Buffer contents: lane k of address a holds {a[7:0], k+1}; B holds {a, 2'b10}.
  function automatic int memA(int addr, int lane);
    return (((addr & 'hFF) << 4) | (lane + 1)) & 'hFFF;
  endfunction

  function automatic int memB(int addr);
    return (((addr & 'h3FF) << 2) | 2) & 'hFFF;
  endfunction

  function automatic logic [WW-1:0] buildWord(int addr);
    logic [WW-1:0] w;
    w = '0;
    w[WW-1:LANES*DW] = '1;
    for (int k = 0; k < LANES; k++) w[k*DW +: DW] = DW'(memA(addr, k));
    return w;
  endfunction

  function automatic string kindName(int kind);
    case (kind)
      EV_CLR:  return "clr";
      EV_RD:   return "rd";
      EV_B:    return "srcb";
      EV_L0:   return "lane0";
      EV_L9:   return "lane9";
      EV_WE:   return "we";
      EV_DONE: return "done";
      default: return "none";
    endcase
  endfunction

  // Synchronous buffer: data appears one cycle after the read strobe.
  always @(posedge clk_i) begin
    if (rd_en_o) begin
      a_rd_data_i <= buildWord(int'(rd_addr_o));
      b_rd_data_i <= DW'(memB(int'(rd_addr_o)));
    end
  end

  task automatic checkOutput(string name, logic [WW-1:0] got, logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic pushEv(int kind, int c, int val);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.val  = val;
    expq.push_back(e);
  endtask

  // Expected events of one job whose first FEED cycle is t, up to cutoff.
  task automatic pushJob(int k, int base, int t, int cutoff);
    int last;
    int a;
    last = (k == 0) ? t + 1 : t + k + LANES + WE_DELAY;
    for (int c = t; c <= last && c <= cutoff; c++) begin
      if (c == t) pushEv(EV_CLR, c, 0);
      if (c < t + k) pushEv(EV_RD, c, (base + c - t) & 'h3FF);
      if (c >= t + 1 && c <= t + k) begin
        a = (base + c - t - 1) & 'h3FF;
        pushEv(EV_B, c, memB(a));
        pushEv(EV_L0, c, memA(a, 0));
      end
      if (c >= t + LANES && c <= t + k + LANES - 1)
        pushEv(EV_L9, c, memA((base + c - t - LANES) & 'h3FF, LANES - 1));
      if (k > 0 && c == t + k + LANES - 1 + WE_DELAY) pushEv(EV_WE, c, 0);
      if (c == last) pushEv(EV_DONE, c, 0);
    end
  endtask

  task automatic handleEvent(int kind, int val);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected %s at cycle %0d: got val %0h expected no event",
               kindName(kind), cyc, val);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != val) begin
        errors++;
        $display("[TB] FAIL event %s: got %s cyc %0d val %0h expected %s cyc %0d val %0h",
                 kindName(e.kind), kindName(kind), cyc, val,
                 kindName(e.kind), e.cyc, e.val);
      end
    end
  endtask

  // Monitor: report every active output on the falling edge.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      checks++;
      if (srca_word_o[WW-1:LANES*DW] !== '0) begin
        errors++;
        $display("[TB] FAIL upper_bits at cycle %0d: got %0h expected 0",
                 cyc, srca_word_o[WW-1:LANES*DW]);
      end
      if (clr_o)  handleEvent(EV_CLR, 0);
      if (rd_en_o) handleEvent(EV_RD, int'(rd_addr_o));
      if (srcb_o != '0) handleEvent(EV_B, int'(srcb_o));
      if (srca_word_o[0 +: DW] != '0) handleEvent(EV_L0, int'(srca_word_o[0 +: DW]));
      if (srca_word_o[(LANES-1)*DW +: DW] != '0)
        handleEvent(EV_L9, int'(srca_word_o[(LANES-1)*DW +: DW]));
      if (we_o)   handleEvent(EV_WE, 0);
      if (done_o) handleEvent(EV_DONE, 0);
    end
  end

  // Issue one start from IDLE; returns the first FEED cycle t.
  task automatic applyStimulus(int k, int base, int cutoff, bit hold, output int t);
    k_len_i     = KW'(k);
    base_addr_i = AW'(base);
    start_i     = 1'b1;
    t = cyc + 1;
    pushJob(k, base, t, cutoff);
    @(posedge clk_i);
    #1;
    if (!hold) start_i = 1'b0;
  endtask

  task automatic waitIdle(string name, int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      #1;
      if (!busy_o && expq.size() == 0) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL timeout %s: got busy %0b pending %0d expected idle with 0 pending",
             name, busy_o, expq.size());
    expq.delete();
  endtask

  task automatic checkAllZero(string tag);
    checkOutput({tag, "_busy"},  WW'(busy_o),    '0);
    checkOutput({tag, "_done"},  WW'(done_o),    '0);
    checkOutput({tag, "_rd_en"}, WW'(rd_en_o),   '0);
    checkOutput({tag, "_addr"},  WW'(rd_addr_o), '0);
    checkOutput({tag, "_clr"},   WW'(clr_o),     '0);
    checkOutput({tag, "_we"},    WW'(we_o),      '0);
    checkOutput({tag, "_srca"},  srca_word_o,    '0);
    checkOutput({tag, "_srcb"},  WW'(srcb_o),    '0);
  endtask

  initial begin
    int t;
    int t2;
    rst_ni      = 1'b0;
    start_i     = 1'b1;
    k_len_i     = KW'(5);
    base_addr_i = '0;

    // Reset with start held: nothing may move.
    repeat (3) @(negedge clk_i);
    checkAllZero("reset");
    #1;
    rst_ni  = 1'b1;
    start_i = 1'b0;
    @(negedge clk_i);
    checkOutput("post_reset_busy", WW'(busy_o), '0);
    #1;

    // K=4 from 0x010: reads 0x010..0x013, lane 9 at T+10..T+13, we T+14, done T+15.
    $display("[TB] job K=4 base=0x010");
    applyStimulus(4, 'h010, 1 << 30, 1'b0, t);
    waitIdle("k4", 60);

    // K=0: clr only, done the next cycle.
    $display("[TB] job K=0");
    applyStimulus(0, 'h055, 1 << 30, 1'b0, t);
    waitIdle("k0", 20);

    // Address wrap 0x3FE..0x001, started right after the previous done.
    $display("[TB] job K=4 base=0x3FE");
    applyStimulus(4, 'h3FE, 1 << 30, 1'b0, t);
    waitIdle("wrap", 60);

    // start_i held high: one job per IDLE entry, second job starts after one idle cycle.
    $display("[TB] start held high");
    applyStimulus(2, 'h040, 1 << 30, 1'b1, t);
    t2 = t + 2 + LANES + WE_DELAY + 2;
    pushJob(2, 'h040, t2, 1 << 30);
    while (cyc < t2) begin
      @(posedge clk_i);
      #1;
    end
    start_i = 1'b0;
    waitIdle("held", 80);
    repeat (3) @(negedge clk_i);
    checkOutput("held_no_third_job", WW'(busy_o), '0);
    #1;

    // Reset at T+6 of a K=8 job: everything stops, later job runs normally.
    $display("[TB] reset mid-job");
    applyStimulus(8, 'h100, 0, 1'b0, t);
    pushJob(8, 'h100, t, t + 5);
    expq.delete();
    pushJob(8, 'h100, t, t + 5);
    while (cyc < t + 6) begin
      @(posedge clk_i);
      #1;
    end
    rst_ni = 1'b0;
    @(negedge clk_i);
    checkAllZero("abort");
    checkOutput("abort_events_seen", WW'(expq.size()), '0);
    repeat (2) @(negedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    #1;
    applyStimulus(3, 'h020, 1 << 30, 1'b0, t);
    waitIdle("after_abort", 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
